// File: rtl/branch_predictor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : CDB_types (package)
//  Brief    : 2-bit saturating counter type, encodings and next-state helper.
//  Revision : 1.0 - initial release
// ============================================================================
package CDB_types;

    typedef logic [1:0] sat_ctr_t;

    localparam sat_ctr_t CTR_SNT = 2'b00;
    localparam sat_ctr_t CTR_WNT = 2'b01;
    localparam sat_ctr_t CTR_WT  = 2'b10;
    localparam sat_ctr_t CTR_ST  = 2'b11;

    function automatic sat_ctr_t sat_ctr_next(input sat_ctr_t ctr, input logic taken);
        sat_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_ctrl_if
//  Brief    : Fetch request/response and commit update bundle of the predictor.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_ctrl_if #(
    parameter int GHR_W = 5,
    parameter int PC_W  = 32
);
    logic             pred_req_valid;
    logic [PC_W-1:0]  pred_req_pc;
    logic             pred_resp_valid;
    logic             pred_taken;
    logic [1:0]       pred_ctr;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic [1:0]       upd_ctr;
    logic             upd_taken;
    logic             upd_mispredict;

    modport master (
        output pred_req_valid, pred_req_pc,
        input  pred_resp_valid, pred_taken, pred_ctr, pred_ghr,
        output upd_valid, upd_pc, upd_ghr, upd_ctr, upd_taken, upd_mispredict
    );

    modport slave (
        input  pred_req_valid, pred_req_pc,
        output pred_resp_valid, pred_taken, pred_ctr, pred_ghr,
        input  upd_valid, upd_pc, upd_ghr, upd_ctr, upd_taken, upd_mispredict
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_ctrl_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : predictor_reg_file
//  Brief    : Counter storage, one write port, synchronous read (pre-write data).
//  Revision : 1.0 - initial release
// ============================================================================
module predictor_reg_file #(
    parameter int DEPTH    = 32,
    parameter int DATA_LEN = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  wire logic [DATA_LEN-1:0]      i_data_in,
    input  wire logic                     i_re,
    input  wire logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic      [DATA_LEN-1:0]      o_data_out
);

    logic [DATA_LEN-1:0] r_mem [DEPTH];
    logic [DATA_LEN-1:0] r_data_out;

    // Read output only moves on a read so the consumer sees a held value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_data_out <= '0;
        end else begin
            if (i_we) r_mem[i_wr_addr] <= i_data_in;
            if (i_re) r_data_out <= r_mem[i_rd_addr];
        end
    end

    assign o_data_out = r_data_out;

endmodule
`default_nettype wire

// File: rtl/branch_predictor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_ctrl
//  Brief    : Gshare/bimodal direction predictor control around the counter table.
//             Define PRED_GSHARE_EN for gshare indexing; bimodal otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_ctrl
    import CDB_types::*;
#(
    parameter int INDEX_W = 5,
    parameter int GHR_W   = 5,
    parameter int PC_W    = 32
) (
    input wire logic               clk,
    input wire logic               rst,
    branch_predictor_ctrl_if.slave bus
);

    localparam int c_DEPTH = 2 ** INDEX_W;

    logic               w_req;
    logic               w_upd;
    logic [INDEX_W-1:0] w_rd_hist;
    logic [INDEX_W-1:0] w_wr_hist;
    logic [INDEX_W-1:0] w_rd_idx;
    logic [INDEX_W-1:0] w_wr_idx;
    sat_ctr_t           w_wr_data;
    sat_ctr_t           w_rf_dout;
    sat_ctr_t           w_pred_ctr;
    logic               w_collide;
    logic               w_resp_valid;
    logic               w_unused;

    logic               r_resp_valid;
    logic [GHR_W-1:0]   r_pred_ghr;
    logic [GHR_W-1:0]   r_spec_ghr;
    logic               r_byp;
    sat_ctr_t           r_byp_ctr;

    assign w_req = bus.pred_req_valid;
    assign w_upd = bus.upd_valid;

`ifdef PRED_GSHARE_EN
    assign w_rd_hist = INDEX_W'(r_spec_ghr);
    assign w_wr_hist = INDEX_W'(bus.upd_ghr);
`else
    assign w_rd_hist = '0;
    assign w_wr_hist = '0;
`endif

    assign w_rd_idx  = bus.pred_req_pc[INDEX_W+1:2] ^ w_rd_hist;
    assign w_wr_idx  = bus.upd_pc[INDEX_W+1:2] ^ w_wr_hist;
    assign w_wr_data = sat_ctr_next(bus.upd_ctr, bus.upd_taken);
    assign w_collide = w_req && w_upd && (w_rd_idx == w_wr_idx);

    // PC offset/upper bits and (in bimodal) the history inputs carry no information here.
    assign w_unused = ^{bus.pred_req_pc, bus.upd_pc, bus.upd_ghr, bus.upd_mispredict};

    predictor_reg_file #(
        .DEPTH    (c_DEPTH),
        .DATA_LEN (2)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_upd),
        .i_wr_addr  (w_wr_idx),
        .i_data_in  (w_wr_data),
        .i_re       (w_req),
        .i_rd_addr  (w_rd_idx),
        .o_data_out (w_rf_dout)
    );

    // Table returns pre-write data on a same-index collision, so the written value is forwarded.
    assign w_pred_ctr   = r_byp ? r_byp_ctr : w_rf_dout;
    assign w_resp_valid = r_resp_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_pred_ghr   <= '0;
            r_spec_ghr   <= '0;
            r_byp        <= 1'b0;
            r_byp_ctr    <= CTR_SNT;
        end else begin
            r_resp_valid <= w_req;
            if (w_req) begin
                r_pred_ghr <= r_spec_ghr;
                r_byp      <= w_collide;
                r_byp_ctr  <= w_wr_data;
            end
`ifdef PRED_GSHARE_EN
            // Mispredict repair wins over the shift of a response in the same cycle.
            if (w_upd && bus.upd_mispredict)
                r_spec_ghr <= GHR_W'({bus.upd_ghr, bus.upd_taken});
            else if (r_resp_valid)
                r_spec_ghr <= GHR_W'({r_spec_ghr, w_pred_ctr[1]});
`else
            r_spec_ghr <= '0;
`endif
        end
    end

    assign bus.pred_resp_valid = w_resp_valid;
    assign bus.pred_ctr        = w_pred_ctr;
    assign bus.pred_taken      = w_pred_ctr[1];
    assign bus.pred_ghr        = r_pred_ghr;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor_ctrl
//  Brief    : Directed scoreboard bench for branch_predictor_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_ctrl;

    typedef struct packed {
        logic [1:0] ctr;
        logic [4:0] ghr;
    } exp_t;

`ifdef PRED_GSHARE_EN
    localparam logic [4:0] c_EXP_RESTORE = 5'b00110;
`else
    localparam logic [4:0] c_EXP_RESTORE = 5'b00000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t       q[$];
    logic [1:0] m_tbl [32];
    logic [4:0] m_ghr;
    logic       m_prev_req;
    logic       m_prev_tk;
    int         n_checks = 0;
    int         n_pass   = 0;

    branch_predictor_ctrl_if #(.GHR_W(5), .PC_W(32)) bus ();

    branch_predictor_ctrl #(
        .INDEX_W (5),
        .GHR_W   (5),
        .PC_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] m_idx(input logic [31:0] pc, input logic [4:0] h);
`ifdef PRED_GSHARE_EN
        return pc[6:2] ^ h;
`else
        return pc[6:2] ^ (h & 5'd0);
`endif
    endfunction

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
        case ({c, t})
            3'b00_0: return 2'b00;
            3'b01_0: return 2'b00;
            3'b10_0: return 2'b01;
            3'b11_0: return 2'b10;
            3'b00_1: return 2'b01;
            3'b01_1: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_tbl[i] = 2'b00;
        m_ghr      = 5'd0;
        m_prev_req = 1'b0;
        m_prev_tk  = 1'b0;
        q.delete();
    endtask

    task automatic check_resp();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("resp_valid", 32'(bus.pred_resp_valid), 32'd1);
            chk("pred_ctr",   32'(bus.pred_ctr),        32'(e.ctr));
            chk("pred_taken", 32'(bus.pred_taken),      32'(e.ctr[1]));
            chk("pred_ghr",   32'(bus.pred_ghr),        32'(e.ghr));
        end else begin
            chk("resp_idle", 32'(bus.pred_resp_valid), 32'd0);
        end
    endtask

    // One clock of stimulus: drive, advance the model, then check at the next negedge.
    task automatic cycle(input logic req, input logic [31:0] rpc,
                         input logic upd, input logic [31:0] upc, input logic [4:0] ughr,
                         input logic [1:0] uctr, input logic utk, input logic umis);
        exp_t       e;
        logic [4:0] ri, wi, nghr;
        bus.pred_req_valid = req;
        bus.pred_req_pc    = rpc;
        bus.upd_valid      = upd;
        bus.upd_pc         = upc;
        bus.upd_ghr        = ughr;
        bus.upd_ctr        = uctr;
        bus.upd_taken      = utk;
        bus.upd_mispredict = umis;
        ri = m_idx(rpc, m_ghr);
        wi = m_idx(upc, ughr);
        e  = '0;
        if (req) begin
            e.ghr = m_ghr;
            e.ctr = (upd && ri == wi) ? m_sat(uctr, utk) : m_tbl[ri];
            q.push_back(e);
        end
        nghr = m_ghr;
`ifdef PRED_GSHARE_EN
        if (upd && umis)     nghr = {ughr[3:0], utk};
        else if (m_prev_req) nghr = {m_ghr[3:0], m_prev_tk};
`endif
        m_ghr = nghr;
        if (upd) m_tbl[wi] = m_sat(uctr, utk);
        m_prev_req = req;
        m_prev_tk  = req ? e.ctr[1] : 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_resp();
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        bus.pred_req_valid = 1'b0;
        bus.pred_req_pc    = '0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_ghr        = '0;
        bus.upd_ctr        = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_mispredict = 1'b0;
        m_reset();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.pred_resp_valid), 32'd0);
        chk("rst_ctr",   32'(bus.pred_ctr),        32'd0);
        chk("rst_taken", 32'(bus.pred_taken),      32'd0);
        chk("rst_ghr",   32'(bus.pred_ghr),        32'd0);
        rst = 1'b0;

        // First prediction from a cleared table
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("first_ctr", 32'(bus.pred_ctr), 32'd0);

        // Two taken updates carry the counter 00 -> 01 -> 10
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 5'd0, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 5'd0, 2'b01, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("train_ctr",   32'(bus.pred_ctr),   32'd2);
        chk("train_taken", 32'(bus.pred_taken), 32'd1);

        // Saturation at both ends
        idle();
        cycle(1'b0, 32'h0, 1'b1, 32'h120, m_ghr, 2'b11, 1'b1, 1'b0);
        cycle(1'b1, 32'h120, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("sat_hi", 32'(bus.pred_ctr), 32'd3);
        idle();
        cycle(1'b0, 32'h0, 1'b1, 32'h140, m_ghr, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 32'h140, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("sat_lo", 32'(bus.pred_ctr), 32'd0);

        // Force history to zero, then request and update the same index together
        idle();
        cycle(1'b0, 32'h0, 1'b1, 32'h300, 5'd0, 2'b00, 1'b0, 1'b1);
        cycle(1'b1, 32'h104, 1'b1, 32'h104, 5'd0, 2'b01, 1'b1, 1'b0);
        chk("collide_ctr", 32'(bus.pred_ctr), 32'd2);
        chk("collide_ghr", 32'(bus.pred_ghr), 32'd0);

        // Taken response and mispredict restore in the same cycle
        idle();
        cycle(1'b0, 32'h0, 1'b1, 32'h180, m_ghr, 2'b11, 1'b1, 1'b0);
        cycle(1'b1, 32'h180, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("pre_restore_taken", 32'(bus.pred_taken), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 32'h1c0, 5'b00011, 2'b01, 1'b0, 1'b1);
        cycle(1'b1, 32'h104, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("restore_ghr", 32'(bus.pred_ghr), 32'(c_EXP_RESTORE));

        // Back-to-back requests exercise the one-cycle-late history shift
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        idle();

        // Reset arriving with a request in flight
        bus.pred_req_valid = 1'b1;
        bus.pred_req_pc    = 32'h100;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.pred_req_valid = 1'b0;
        @(negedge clk);
        chk("rst_inflight_valid", 32'(bus.pred_resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("post_rst_ctr_100", 32'(bus.pred_ctr), 32'd0);
        cycle(1'b1, 32'h180, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("post_rst_ctr_180", 32'(bus.pred_ctr), 32'd0);
        cycle(1'b1, 32'h120, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
        chk("post_rst_ctr_120", 32'(bus.pred_ctr), 32'd0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor_ctrl.md
# branch_predictor_ctrl

Gshare-style branch direction predictor control stage wrapping the 2-bit saturating counter table (`predictor_reg_file`, synchronous read, 1-cycle latency).
- Fetch side: forms the table index from fetch PC and speculative global history, then returns a prediction one cycle later.
- Commit side: writes back saturated counter updates and repairs the speculative history on mispredict.
- Sits between fetch (upstream) and the counter table (downstream).

## Interface
- INDEX_W, 5, table index width; table depth = 2^INDEX_W
- GHR_W, 5, global history length; must be ≤ INDEX_W
- PC_W, 32, PC width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- pred_req_valid  in  1  fetch requests a prediction this cycle
- pred_req_pc  in  PC_W  fetch PC
- pred_resp_valid  out  1  prediction valid (one cycle after request)
- pred_taken  out  1  predicted direction (= pred_ctr[1])
- pred_ctr  out  2  counter value read; carried to commit
- pred_ghr  out  GHR_W  history snapshot used to form the index; carried to commit
- upd_valid  in  1  commit-time branch resolution
- upd_pc  in  PC_W  resolved branch PC
- upd_ghr  in  GHR_W  snapshot returned from pred_ghr
- upd_ctr  in  2  counter returned from pred_ctr
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  predicted direction was wrong

## Operation
- Index function:
  - idx(pc, h) = pc[INDEX_W+1:2] XOR zero-extend(h).
  - Read index uses `spec_ghr`; write index uses `upd_ghr`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Update path:
  - When upd_valid, table `we=1` the same cycle.
  - wr_addr = idx(upd_pc, upd_ghr); data_in = sat(upd_ctr, upd_taken).
  - No read-modify-write; the counter value travels with the branch.
- Speculative history:
  - On each pred_resp_valid: `spec_ghr <= {spec_ghr[GHR_W-2:0], pred_taken}`.
  - On upd_valid && upd_mispredict: `spec_ghr <= {upd_ghr[GHR_W-2:0], upd_taken}`.
  - Restore has priority over a same-cycle shift; that shift is discarded.
  - The response itself is still emitted; squashing it is the consumer's job.
- Write/read collision:
  - The table returns pre-write data when reading and writing the same address in the same cycle.
  - If a request and an update hit the same index in the same cycle, the block registers the written counter and forwards it at T+1 instead of the table output.
- Outputs pred_taken, pred_ctr, pred_ghr hold their last value while pred_resp_valid=0.

## Timing
- Cycle T, request accepted (no back-pressure, one per cycle): rd_addr = idx(pred_req_pc, spec_ghr); pred_ghr snapshot registered.
- Cycle T+1: pred_resp_valid=1 with pred_ctr/pred_taken/pred_ghr.
- A request at T+1 uses spec_ghr that does not yet include T's prediction (shift lands at end of T+1).
- Reset values:
  - pred_resp_valid=0, pred_taken=0, pred_ctr=00, pred_ghr=0, spec_ghr=0, bypass flag=0.
  - Table entries = 00.
- rst dominates: requests and updates in a reset cycle are dropped.
- rst asserted with a request in flight: no response at T+1.

## Configuration
- Macro `PRED_GSHARE_EN`.
- Defined: gshare indexing and history exactly as above.
- Undefined (bimodal):
  - idx = pc[INDEX_W+1:2].
  - spec_ghr is held at 0; pred_ghr outputs 0.
  - upd_ghr is ignored; mispredict restore has no effect.

## Structure
- Shared package `CDB_types` adds:
  - typedef `sat_ctr_t` (logic [1:0]);
  - constants `CTR_SNT/CTR_WNT/CTR_WT/CTR_ST`;
  - function `sat_ctr_next(sat_ctr_t, logic)`.
- One sub-module: `predictor_reg_file` instance (DEPTH=2^INDEX_W, DATA_LEN=2) as counter storage.
- Index hashing and GHR logic stay inline.

## Test plan
Default parameters, `PRED_GSHARE_EN` defined.
- Reset, then request pc=0x100 → next cycle pred_resp_valid=1, pred_ctr=00, pred_taken=0, pred_ghr=0.
- Update pc=0x100, ghr=0, ctr=00, taken=1, then pc=0x100, ctr=01, taken=1 (no requests in between) → request pc=0x100 returns ctr=10, taken=1.
- Saturation:
  - upd_ctr=11, taken=1 → entry written 11;
  - upd_ctr=00, taken=0 → entry written 00.
- Collision: spec_ghr=0, same cycle request pc=0x104 and update pc=0x104, ghr=0, ctr=01, taken=1 → next cycle pred_ctr=10 (forwarded).
- Restore priority: response with taken=1 in the same cycle as mispredict upd_ghr=00011, upd_taken=0 → spec_ghr=00110.
- rst pulsed the cycle after a request → pred_resp_valid stays 0; a subsequent read of any index returns 00.
